// File: rtl/divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// One load edge, then N shift/subtract steps; the work register is visible on the outputs.
module divider #(
    parameter int unsigned N = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ready,
    output logic           overflow
);

    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N:0]      r_q, r_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    d_q, d_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            overflow_q, overflow_d;

    logic [2*N:0]    w_sh;
    logic [N:0]      r_sh;
    logic [N:0]      r_sub;
    logic [N-1:0]    q_sh;
    logic [N-1:0]    dividend_hi;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            q_q        <= q_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        overflow_d  = overflow_q;

        dividend_hi = dividend[2*N-1:N];
        w_sh        = {r_q, q_q} << 1;
        r_sh        = w_sh[2*N:N];
        q_sh        = w_sh[N-1:0];
        r_sub       = r_sh - {1'b0, d_q};

        if (start) begin
            d_d        = divisor;
            cnt_d      = CntW'(N);
            ready_d    = 1'b0;
            overflow_d = 1'b0;
            // High half >= divisor means the quotient cannot fit in N bits (covers divisor==0).
            if (dividend_hi >= divisor) begin
                r_d        = '0;
                q_d        = '1;
                overflow_d = 1'b1;
                ready_d    = 1'b1;
                state_d    = StDone;
            end else begin
                r_d     = {1'b0, dividend_hi};
                q_d     = dividend[N-1:0];
                state_d = StRun;
            end
        end else if (state_q == StRun) begin
            r_d = r_sh;
            q_d = q_sh;
            if (r_sh >= {1'b0, d_q}) begin
                r_d    = r_sub;
                q_d[0] = 1'b1;
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
                ready_d = 1'b1;
                state_d = StDone;
            end
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q[N-1:0];
    assign ready     = ready_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the driver queues expected outputs per clock edge,
// a monitor 1 time unit after each posedge pops and compares them.
module tb_divider;

    localparam int unsigned N = 4;

    logic           clock;
    logic           reset_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           ready;
    logic           overflow;

    divider #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .ready     (ready),
        .overflow  (overflow)
    );

    typedef struct {
        int           cyc;
        string        name;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         rdy;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this edge.
    always @(posedge clock) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || quotient !== e.q || remainder !== e.r ||
                ready !== e.rdy || overflow !== e.ovf) begin
                errors++;
                $display("FAIL %s @cyc %0d (due %0d): got q=%0d r=%0d ready=%b ovf=%b, expected q=%0d r=%0d ready=%b ovf=%b",
                         e.name, cyc, e.cyc, quotient, remainder, ready, overflow,
                         e.q, e.r, e.rdy, e.ovf);
            end
        end
    end

    task automatic expect_at(input string name, input int offset, input int q, input int r,
                             input logic rdy, input logic ovf);
        exp_t e;
        e.cyc  = cyc + offset;
        e.name = name;
        e.q    = q[N-1:0];
        e.r    = r[N-1:0];
        e.rdy  = rdy;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Drive a load for exactly one edge; operands are scrambled afterwards.
    task automatic load(input int dvd, input int dvs);
        start    = 1'b1;
        dividend = dvd[2*N-1:0];
        divisor  = dvs[N-1:0];
        step();
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 4'h7;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b1;
        dividend = 8'd66;
        divisor  = 4'd11;

        // Reset beats start
        expect_at("reset_e1", 1, 0, 0, 1'b0, 1'b0);
        expect_at("reset_e2", 2, 0, 0, 1'b0, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        start   = 1'b0;
        expect_at("idle_after_reset", 1, 0, 0, 1'b0, 1'b0);
        step();

        // 66/11: every intermediate stage
        expect_at("66_11_load", 1, 2, 4, 1'b0, 1'b0);
        load(66, 11);
        expect_at("66_11_s1", 1, 4, 8, 1'b0, 1'b0);
        expect_at("66_11_s2", 2, 9, 5, 1'b0, 1'b0);
        expect_at("66_11_s3", 3, 3, 0, 1'b0, 1'b0);
        expect_at("66_11_s4", 4, 6, 0, 1'b1, 1'b0);
        expect_at("66_11_hold", 5, 6, 0, 1'b1, 1'b0);
        repeat (5) step();

        // 200/13 with remainder, then three idle holds
        expect_at("200_13_load", 1, 8, 12, 1'b0, 1'b0);
        load(200, 13);
        expect_at("200_13_s1", 1, 1, 12, 1'b0, 1'b0);
        expect_at("200_13_s2", 2, 3, 11, 1'b0, 1'b0);
        expect_at("200_13_s3", 3, 7, 9, 1'b0, 1'b0);
        expect_at("200_13_s4", 4, 15, 5, 1'b1, 1'b0);
        expect_at("200_13_hold1", 5, 15, 5, 1'b1, 1'b0);
        expect_at("200_13_hold2", 6, 15, 5, 1'b1, 1'b0);
        expect_at("200_13_hold3", 7, 15, 5, 1'b1, 1'b0);
        repeat (7) step();

        // Overflow on the load edge
        expect_at("ovf_200_12", 1, 15, 0, 1'b1, 1'b1);
        load(200, 12);
        expect_at("ovf_200_12_hold", 1, 15, 0, 1'b1, 1'b1);
        step();
        expect_at("ovf_div0", 1, 15, 0, 1'b1, 1'b1);
        load(5, 0);

        // Restart during RUN after step 2 (also clears overflow)
        expect_at("rst_a_load", 1, 2, 4, 1'b0, 1'b0);
        load(66, 11);
        expect_at("rst_a_s1", 1, 4, 8, 1'b0, 1'b0);
        expect_at("rst_a_s2", 2, 9, 5, 1'b0, 1'b0);
        repeat (2) step();
        expect_at("rst_b_load", 1, 8, 12, 1'b0, 1'b0);
        load(200, 13);
        expect_at("rst_b_s1", 1, 1, 12, 1'b0, 1'b0);
        expect_at("rst_b_s2", 2, 3, 11, 1'b0, 1'b0);
        expect_at("rst_b_s3", 3, 7, 9, 1'b0, 1'b0);
        expect_at("rst_b_s4", 4, 15, 5, 1'b1, 1'b0);
        repeat (4) step();

        // Reset during step 2 of 66/11
        expect_at("abort_load", 1, 2, 4, 1'b0, 1'b0);
        load(66, 11);
        expect_at("abort_s1", 1, 4, 8, 1'b0, 1'b0);
        step();
        reset_n = 1'b0;
        expect_at("abort_reset", 1, 0, 0, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        expect_at("abort_idle1", 1, 0, 0, 1'b0, 1'b0);
        expect_at("abort_idle2", 2, 0, 0, 1'b0, 1'b0);
        expect_at("abort_idle5", 5, 0, 0, 1'b0, 1'b0);
        repeat (5) step();

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Sequential restoring divider; the inverse of the team's shift-add `multiplier`. It divides a 2N-bit dividend by an N-bit divisor and produces an N-bit quotient and an N-bit remainder. Timing and handshake match `multiplier`: one load cycle on start, then N iteration cycles, then `ready`. The working register is exposed on the outputs throughout, so a bench can check intermediate stages.

Parameters:
N, 4, datapath width in bits (divisor, quotient, remainder); dividend is 2N bits.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset_n  input  1  synchronous, active-low reset, sampled on clock posedge.
start  input  1  request; sampled on posedge; loads operands and begins a division.
dividend  input  2N  dividend; sampled only on the load edge.
divisor  input  N  divisor; sampled only on the load edge.
quotient  output  N  low half of working register; final quotient when ready=1.
remainder  output  N  high half of working register; final remainder when ready=1.
ready  output  1  1 = result valid; held until next start or reset.
overflow  output  1  1 = quotient does not fit in N bits (includes divisor==0); valid when ready=1.

Behaviour:
- Reset: on any posedge with reset_n=0, quotient=0, remainder=0, ready=0, overflow=0, state=IDLE, iteration counter cleared. Reset beats start and aborts any division in progress.
- State register: a work register W = {R[N:0], Q[N-1:0]}, where R carries one extra bit for the shift carry. Also a stored divisor D[N-1:0] and a counter CNT counting 0..N.
- Output mapping: remainder=R[N-1:0] and quotient=Q at all times, including intermediate stages.
- States: IDLE, RUN, DONE.
- Load (posedge k, reset_n=1, start=1, from any state):
  - D=divisor; R={1'b0, dividend[2N-1:N]}; Q=dividend[N-1:0]; CNT=N; ready=0; overflow=0.
  - If dividend[2N-1:N] >= divisor (unsigned; always true when divisor=0): instead set R=0, Q={N{1'b1}}, overflow=1, ready=1, state=DONE at this same edge.
  - Otherwise state=RUN.
- RUN step (each posedge with start=0):
  - Shift W left 1 with 0 in.
  - If R >= {1'b0, D}: R=R-D and Q[0]=1.
  - Decrement CNT.
  - On the step where CNT goes 1->0: ready=1, state=DONE.
  - Latency: ready visible after posedge k+N. For N=4 that is 5 edges including the load edge.
- start=1 during RUN or DONE restarts a new division (load semantics). The in-flight result is discarded.
- DONE/IDLE hold all outputs stable while start=0. Operand input changes after the load edge have no effect.
- Arithmetic is unsigned only. No divisor==0 trap beyond the overflow flag.

Test Plan:
- Reset: reset_n=0 for 2 posedges with start=1 -> quotient=0, remainder=0, ready=0, overflow=0; start is ignored.
- Exact division, N=4: dividend=66, divisor=11, start for one edge.
  - {remainder,quotient} after each edge: load 8'd66 (q=2,r=4), then 132 (q=4,r=8), 89 (q=9,r=5), 3 (q=3,r=0), 6 (q=6,r=0).
  - ready=0 through step 3; ready=1 and overflow=0 after step 4.
- Remainder case: 200/13 -> after load+4 edges quotient=15, remainder=5, ready=1, overflow=0. Outputs hold for 3 further idle edges.
- Overflow cases, each on the load edge itself:
  - 200/12 -> ready=1, overflow=1, quotient=15, remainder=0.
  - divisor=0, dividend=5 -> same response.
- Restart: start 66/11, then reassert start with 200/13 after step 2 -> final quotient=15, remainder=5 at load+4 edges from the second start; ready stays 0 in between.
- Reset mid-operation: reset_n=0 during step 2 of 66/11 -> all outputs 0 at that edge. After release with start=0, the block stays idle with outputs 0.
